// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared widths and type definitions for the external asynchronous SRAM
// arbiter: bus widths, the access sequencer state encoding and the port
// selector used to remember which requester owns the current cycle.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

   // Access sequencer states: idle, address setup, strobe, hold/ack
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } arbState_t;

   // Which requester owns the transaction in flight
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } portSel_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way request arbiter with a last-grant pointer.
//
// Ports:
//   CLK       clock
//   reset_in  asynchronous active-high reset (pointer returns to "B last")
//   req_i     request vector, bit0 = port A, bit1 = port B
//   update_i  strobe: the current grant is being taken, move the pointer
//   grant_o   one-hot grant (combinational from req_i and the pointer)
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN to make A always win over B;
// otherwise ties alternate round-robin starting with A after reset.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       CLK,
   input  logic       reset_in,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);

   logic lastB_q;
   logic lastB_d;

   // Grant selection; on a tie the port that was not served last wins,
   // unless fixed priority is built in, in which case A always wins
   always_comb begin
      grant_o = 2'b00;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      grant_o[0] = req_i[0];
      grant_o[1] = req_i[1] & ~req_i[0];
`else
      if (req_i == 2'b11) begin
         grant_o = lastB_q ? 2'b01 : 2'b10;
      end else begin
         grant_o = req_i;
      end
`endif
   end

   // Pointer follows whichever port was actually granted
   always_comb begin
      lastB_d = lastB_q;
      if (update_i) begin
         lastB_d = grant_o[1];
      end
   end

   // Pointer register; reset to "B last" so A wins the first tie
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         lastB_q <= 1'b1;
      end else begin
         lastB_q <= lastB_d;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one external 16-bit asynchronous SRAM between the SoC bus (port A)
// and the QSPI bridge (port B). Each access is a fixed
// SETUP -> ACCESS (WAIT_CYCLES clocks) -> HOLD sequence; every output is
// registered, so nothing on the pins or acks depends combinationally on req.
//
// Parameters:
//   WAIT_CYCLES    strobe length in clocks, 1..15
// Ports:
//   CLK, reset_in                      clock, async active-high reset
//   a_*/b_* req, we, addr, wdata, be   requester inputs, held until ack
//   a_ack, b_ack                       one-cycle completion pulse
//   a_rdata, b_rdata                   read data, held until next read ack
//   sram_addr, sram_dat_write          SRAM address / data to the pads
//   sram_dat_oe                        pad output enable
//   sram_dat_read                      data from the pads
//   sram_cs_n/we_n/oe_n/lb_n/ub_n      active-low SRAM strobes
// Build option: SRAM_ARB_FIXED_PRIO_EN (see rr_arbiter2).
// -----------------------------------------------------------------------------
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   CLK,
   input  logic                   reset_in,
   input  logic                   a_req,
   input  logic                   a_we,
   input  logic [SRAM_ADDR_W-1:0] a_addr,
   input  logic [SRAM_DATA_W-1:0] a_wdata,
   input  logic [1:0]             a_be,
   output logic                   a_ack,
   output logic [SRAM_DATA_W-1:0] a_rdata,
   input  logic                   b_req,
   input  logic                   b_we,
   input  logic [SRAM_ADDR_W-1:0] b_addr,
   input  logic [SRAM_DATA_W-1:0] b_wdata,
   input  logic [1:0]             b_be,
   output logic                   b_ack,
   output logic [SRAM_DATA_W-1:0] b_rdata,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dat_write,
   output logic                   sram_dat_oe,
   input  logic [SRAM_DATA_W-1:0] sram_dat_read,
   output logic                   sram_cs_n,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   output logic                   sram_lb_n,
   output logic                   sram_ub_n
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   arbState_t              state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   portSel_t               sel_q, sel_d;
   logic                   latWe_q, latWe_d;
   logic [1:0]             latBe_q, latBe_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic                   datOe_q, datOe_d;
   logic                   csN_q, csN_d;
   logic                   weN_q, weN_d;
   logic                   oeN_q, oeN_d;
   logic                   lbN_q, lbN_d;
   logic                   ubN_q, ubN_d;
   logic                   aAck_q, aAck_d;
   logic                   bAck_q, bAck_d;
   logic [SRAM_DATA_W-1:0] aRdata_q, aRdata_d;
   logic [SRAM_DATA_W-1:0] bRdata_q, bRdata_d;
   logic [1:0]             grant;
   logic                   grantUpdate;

   rr_arbiter2 uArb (
      .CLK      (CLK),
      .reset_in (reset_in),
      .req_i    ({b_req, a_req}),
      .update_i (grantUpdate),
      .grant_o  (grant)
   );

   // Sequencer next state. The pin values are computed for the state being
   // entered so that the registered pins line up with the state itself.
   // Reads enable both byte lanes; writes use the inverted byte enables.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      latWe_d     = latWe_q;
      latBe_d     = latBe_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      datOe_d     = 1'b0;
      csN_d       = 1'b1;
      weN_d       = 1'b1;
      oeN_d       = 1'b1;
      lbN_d       = 1'b1;
      ubN_d       = 1'b1;
      aAck_d      = 1'b0;
      bAck_d      = 1'b0;
      aRdata_d    = aRdata_q;
      bRdata_d    = bRdata_q;
      grantUpdate = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               grantUpdate = 1'b1;
               state_d     = SETUP;
               if (grant[1]) begin
                  sel_d   = PORT_B;
                  latWe_d = b_we;
                  latBe_d = b_be;
                  addr_d  = b_addr;
                  if (b_we) begin
                     wdata_d = b_wdata;
                  end
               end else begin
                  sel_d   = PORT_A;
                  latWe_d = a_we;
                  latBe_d = a_be;
                  addr_d  = a_addr;
                  if (a_we) begin
                     wdata_d = a_wdata;
                  end
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
               if (sel_q == PORT_B) begin
                  bAck_d = 1'b1;
                  if (!latWe_q) begin
                     bRdata_d = sram_dat_read;
                  end
               end else begin
                  aAck_d = 1'b1;
                  if (!latWe_q) begin
                     aRdata_d = sram_dat_read;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != IDLE) begin
         csN_d   = 1'b0;
         datOe_d = latWe_d;
         lbN_d   = latWe_d ? ~latBe_d[0] : 1'b0;
         ubN_d   = latWe_d ? ~latBe_d[1] : 1'b0;
      end
      if (state_d == ACCESS) begin
         weN_d = ~latWe_d;
         oeN_d = latWe_d;
      end
   end

   // State and output registers; reset drops every strobe immediately,
   // which also aborts any transaction in flight without an ack
   always_ff @(posedge CLK or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         sel_q    <= PORT_A;
         latWe_q  <= 1'b0;
         latBe_q  <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         datOe_q  <= 1'b0;
         csN_q    <= 1'b1;
         weN_q    <= 1'b1;
         oeN_q    <= 1'b1;
         lbN_q    <= 1'b1;
         ubN_q    <= 1'b1;
         aAck_q   <= 1'b0;
         bAck_q   <= 1'b0;
         aRdata_q <= '0;
         bRdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         latWe_q  <= latWe_d;
         latBe_q  <= latBe_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         datOe_q  <= datOe_d;
         csN_q    <= csN_d;
         weN_q    <= weN_d;
         oeN_q    <= oeN_d;
         lbN_q    <= lbN_d;
         ubN_q    <= ubN_d;
         aAck_q   <= aAck_d;
         bAck_q   <= bAck_d;
         aRdata_q <= aRdata_d;
         bRdata_q <= bRdata_d;
      end
   end

   assign sram_addr      = addr_q;
   assign sram_dat_write = wdata_q;
   assign sram_dat_oe    = datOe_q;
   assign sram_cs_n      = csN_q;
   assign sram_we_n      = weN_q;
   assign sram_oe_n      = oeN_q;
   assign sram_lb_n      = lbN_q;
   assign sram_ub_n      = ubN_q;
   assign a_ack          = aAck_q;
   assign b_ack          = bAck_q;
   assign a_rdata        = aRdata_q;
   assign b_rdata        = bRdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter. A behavioural SRAM sits on the pins;
// expected acks, timing and read data come from a transaction-level model
// (shadow memory plus a "served last" flag). Two extra instances with
// WAIT_CYCLES = 1 and 15 cover the latency extremes.
// Honours SRAM_ARB_FIXED_PRIO_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int W = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        aReq, bReq, aWe, bWe;
   logic [17:0] aAddr, bAddr;
   logic [15:0] aWdata, bWdata;
   logic [1:0]  aBe, bBe;
   logic        aAck, bAck;
   logic [15:0] aRdata, bRdata;
   logic [17:0] sramAddr;
   logic [15:0] sramDatWrite, sramDatRead;
   logic        sramDatOe, csN, weN, oeN, lbN, ubN;

   logic        xReq [2];
   logic        xAck [2];

   int          chkCount = 0;
   int          errCount = 0;

   logic [15:0] mem    [int];
   logic [15:0] shadow [int];

   int          ackPortQ [$];
   int          ackCycQ  [$];
   logic [15:0] ackDataQ [$];
   bit          weTrace [$];
   bit          oeDatTrace [$];
   bit          lbTrace [$];
   bit          ubTrace [$];

   always #5 clock = ~clock;

   sram_arbiter #(.WAIT_CYCLES(W)) uDut (
      .CLK            (clock),
      .reset_in       (reset),
      .a_req          (aReq),
      .a_we           (aWe),
      .a_addr         (aAddr),
      .a_wdata        (aWdata),
      .a_be           (aBe),
      .a_ack          (aAck),
      .a_rdata        (aRdata),
      .b_req          (bReq),
      .b_we           (bWe),
      .b_addr         (bAddr),
      .b_wdata        (bWdata),
      .b_be           (bBe),
      .b_ack          (bAck),
      .b_rdata        (bRdata),
      .sram_addr      (sramAddr),
      .sram_dat_write (sramDatWrite),
      .sram_dat_oe    (sramDatOe),
      .sram_dat_read  (sramDatRead),
      .sram_cs_n      (csN),
      .sram_we_n      (weN),
      .sram_oe_n      (oeN),
      .sram_lb_n      (lbN),
      .sram_ub_n      (ubN)
   );

   // Extra instances used only for the latency extremes
   for (genvar g = 0; g < 2; g++) begin : gExtra
      logic        bAckX, datOeX, csX, weX, oeX, lbX, ubX;
      logic [15:0] aRdX, bRdX, datWrX;
      logic [17:0] addrX;
      sram_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 15)) uDutX (
         .CLK            (clock),
         .reset_in       (reset),
         .a_req          (xReq[g]),
         .a_we           (1'b1),
         .a_addr         (18'h5),
         .a_wdata        (16'h0),
         .a_be           (2'b11),
         .a_ack          (xAck[g]),
         .a_rdata        (aRdX),
         .b_req          (1'b0),
         .b_we           (1'b0),
         .b_addr         (18'h0),
         .b_wdata        (16'h0),
         .b_be           (2'b00),
         .b_ack          (bAckX),
         .b_rdata        (bRdX),
         .sram_addr      (addrX),
         .sram_dat_write (datWrX),
         .sram_dat_oe    (datOeX),
         .sram_dat_read  (16'h0),
         .sram_cs_n      (csX),
         .sram_we_n      (weX),
         .sram_oe_n      (oeX),
         .sram_lb_n      (lbX),
         .sram_ub_n      (ubX)
      );
   end

   function automatic logic [15:0] memRd(input int a);
      return mem.exists(a) ? mem[a] : 16'hFFFF;
   endfunction

   function automatic logic [15:0] shRd(input int a);
      return shadow.exists(a) ? shadow[a] : 16'hFFFF;
   endfunction

   // Behavioural asynchronous SRAM: drives data while selected and output
   // enabled, and stores the enabled byte lanes while write-strobed
   assign sramDatRead = (!csN && !oeN) ? memRd(int'(sramAddr)) : 16'hDEAD;

   always @(posedge clock) begin
      logic [15:0] w;
      if (!reset && !csN && !weN) begin
         w = memRd(int'(sramAddr));
         if (!lbN) w[7:0]  = sramDatWrite[7:0];
         if (!ubN) w[15:8] = sramDatWrite[15:8];
         mem[int'(sramAddr)] = w;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      chkCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit port, input bit we, input logic [17:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be);
      if (port) begin
         bWe = we; bAddr = addr; bWdata = wdata; bBe = be; bReq = 1'b1;
      end else begin
         aWe = we; aAddr = addr; aWdata = wdata; aBe = be; aReq = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic resetDut();
      aReq = 1'b0; bReq = 1'b0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   // Runs clocks until nAcks acks are seen or the budget runs out. A port
   // drops its request on its ack unless held; dropA > 0 drops A's request
   // after that many clocks regardless.
   task automatic runUntil(input int nAcks, input int budget, input bit holdA,
                           input bit holdB, input int dropA);
      int cyc = 0;
      ackPortQ.delete(); ackCycQ.delete(); ackDataQ.delete();
      weTrace.delete(); oeDatTrace.delete(); lbTrace.delete(); ubTrace.delete();
      while (ackPortQ.size() < nAcks && cyc < budget) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         weTrace.push_back(weN);
         oeDatTrace.push_back(sramDatOe);
         lbTrace.push_back(lbN);
         ubTrace.push_back(ubN);
         if (dropA == cyc) aReq = 1'b0;
         if (aAck) begin
            ackPortQ.push_back(0); ackCycQ.push_back(cyc); ackDataQ.push_back(aRdata);
            if (!holdA) aReq = 1'b0;
         end
         if (bAck) begin
            ackPortQ.push_back(1); ackCycQ.push_back(cyc); ackDataQ.push_back(bRdata);
            if (!holdB) bReq = 1'b0;
         end
      end
      checkOutput("ackCount", ackPortQ.size(), nAcks);
   endtask

   function automatic logic [7:0] packTrace(input bit q [$]);
      logic [7:0] p = '0;
      for (int i = 0; i < q.size() && i < 8; i++) p[i] = q[i];
      return p;
   endfunction

   initial begin
      int          lat [2];
      int          cnt;
      int          mode;
      int          nExp;
      int          order [2];
      bit          lastB;
      bit          fixedPrio;
      bit          tWe [2];
      logic [17:0] tAddr [2];
      logic [15:0] tWdata [2];
      logic [1:0]  tBe [2];
      logic [15:0] w;
      int          p;

`ifdef SRAM_ARB_FIXED_PRIO_EN
      fixedPrio = 1'b1;
`else
      fixedPrio = 1'b0;
`endif
      reset = 1'b1;
      aReq = 0; bReq = 0; aWe = 0; bWe = 0; aAddr = 0; bAddr = 0;
      aWdata = 0; bWdata = 0; aBe = 0; bBe = 0;
      xReq[0] = 0; xReq[1] = 0;
      idle(2);

      // Reset state
      checkOutput("rst_strobes", {27'd0, csN, weN, oeN, lbN, ubN}, 32'h1F);
      checkOutput("rst_datoe", sramDatOe, 0);
      checkOutput("rst_addr", sramAddr, 0);
      checkOutput("rst_wdata", sramDatWrite, 0);
      checkOutput("rst_rdata", {aRdata, bRdata}, 0);
      checkOutput("rst_acks", {aAck, bAck}, 0);
      reset = 1'b0;

      // Latency extremes on the WAIT_CYCLES=1 and 15 instances
      xReq[0] = 1'b1; xReq[1] = 1'b1;
      lat[0] = 0; lat[1] = 0;
      for (int c = 1; c <= 40 && (lat[0] == 0 || lat[1] == 0); c++) begin
         @(posedge clock);
         @(negedge clock);
         for (int g = 0; g < 2; g++) begin
            if (xAck[g] && lat[g] == 0) begin
               lat[g] = c;
               xReq[g] = 1'b0;
            end
         end
      end
      xReq[0] = 1'b0; xReq[1] = 1'b0;
      checkOutput("lat_wait1", lat[0], 3);
      checkOutput("lat_wait15", lat[1], 17);

      // Single write, then read back
      applyStimulus(0, 1, 18'h00010, 16'h1234, 2'b11);
      runUntil(1, 20, 0, 0, 0);
      if (ackPortQ.size() > 0) begin
         checkOutput("wr_port", ackPortQ[0], 0);
         checkOutput("wr_ackcyc", ackCycQ[0], W + 2);
      end
      checkOutput("wr_we_trace", packTrace(weTrace), 8'h09);
      checkOutput("wr_datoe_trace", packTrace(oeDatTrace), 8'h0F);
      idle(1);
      checkOutput("wr_datoe_off", sramDatOe, 0);
      checkOutput("wr_mem", memRd(32'h10), 16'h1234);

      applyStimulus(0, 0, 18'h00010, 16'h0, 2'b00);
      runUntil(1, 20, 0, 0, 0);
      if (ackPortQ.size() > 0) begin
         checkOutput("rd_ackcyc", ackCycQ[0], W + 2);
         checkOutput("rd_data", ackDataQ[0], 16'h1234);
      end
      idle(1);

      // Byte lane write from B
      applyStimulus(1, 1, 18'h00020, 16'hAB55, 2'b01);
      runUntil(1, 20, 0, 0, 0);
      if (ackPortQ.size() > 0) checkOutput("bl_port", ackPortQ[0], 1);
      checkOutput("bl_lb_trace", packTrace(lbTrace), 8'h00);
      checkOutput("bl_ub_trace", packTrace(ubTrace), 8'h0F);
      checkOutput("bl_mem", memRd(32'h20), 16'hFF55);
      idle(1);

      // Request dropped during ACCESS
      applyStimulus(0, 0, 18'h00020, 16'h0, 2'b11);
      runUntil(1, 20, 0, 0, 2);
      if (ackPortQ.size() > 0) begin
         checkOutput("drop_ackcyc", ackCycQ[0], W + 2);
         checkOutput("drop_data", ackDataQ[0], 16'hFF55);
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         if (!csN || aAck || bAck) cnt++;
      end
      checkOutput("drop_no_extra", cnt, 0);
      checkOutput("rdata_held", aRdata, 16'hFF55);

      // Simultaneous requests from reset, both held
      resetDut();
      applyStimulus(0, 1, 18'h00030, 16'h1111, 2'b11);
      applyStimulus(1, 1, 18'h00031, 16'h2222, 2'b11);
      runUntil(4, 40, 1, 1, 0);
      aReq = 1'b0; bReq = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k < ackPortQ.size()) begin
            checkOutput($sformatf("sim_port%0d", k), ackPortQ[k],
                        fixedPrio ? 0 : (k % 2));
            checkOutput($sformatf("sim_cyc%0d", k), ackCycQ[k], (W + 2) + k * (W + 3));
         end
      end
      idle(1);

      // Reset during a write strobe
      applyStimulus(0, 1, 18'h3FFFF, 16'h5A5A, 2'b11);
      idle(2);
      checkOutput("rm_we_low", weN, 0);
      reset = 1'b1;
      #1;
      checkOutput("rm_strobes", {29'd0, csN, weN, oeN}, 32'h7);
      checkOutput("rm_datoe", sramDatOe, 0);
      aReq = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (aAck || bAck) cnt++;
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (aAck || bAck) cnt++;
      end
      checkOutput("rm_no_ack", cnt, 0);
      applyStimulus(0, 0, 18'h00010, 16'h0, 2'b00);
      runUntil(1, 20, 0, 0, 0);
      if (ackPortQ.size() > 0) begin
         checkOutput("rm_after_cyc", ackCycQ[0], W + 2);
         checkOutput("rm_after_data", ackDataQ[0], 16'h1234);
      end
      idle(1);

      // Randomized traffic against the transaction-level model
      resetDut();
      lastB = 1'b1;
      for (int r = 0; r < 12; r++) begin
         mode = $urandom_range(0, 2);
         for (int q = 0; q < 2; q++) begin
            tWe[q]    = 1'($urandom_range(0, 1));
            tAddr[q]  = 18'($urandom_range(0, 15));
            tWdata[q] = 16'($urandom);
            tBe[q]    = 2'($urandom_range(0, 3));
         end
         if (mode != 1) applyStimulus(0, tWe[0], tAddr[0], tWdata[0], tBe[0]);
         if (mode != 0) applyStimulus(1, tWe[1], tAddr[1], tWdata[1], tBe[1]);
         if (mode == 2) begin
            nExp = 2;
            order[0] = (fixedPrio || lastB) ? 0 : 1;
            order[1] = 1 - order[0];
         end else begin
            nExp = 1;
            order[0] = mode;
            order[1] = mode;
         end
         runUntil(nExp, 3 * (W + 3) + 4, 0, 0, 0);
         for (int k = 0; k < nExp; k++) begin
            p = order[k];
            if (k < ackPortQ.size()) begin
               checkOutput($sformatf("rnd%0d_port%0d", r, k), ackPortQ[k], p);
               checkOutput($sformatf("rnd%0d_cyc%0d", r, k), ackCycQ[k],
                           (W + 2) + k * (W + 3));
               if (!tWe[p]) begin
                  checkOutput($sformatf("rnd%0d_data%0d", r, k), ackDataQ[k],
                              shRd(int'(tAddr[p])));
               end
            end
            if (tWe[p]) begin
               w = shRd(int'(tAddr[p]));
               if (tBe[p][0]) w[7:0]  = tWdata[p][7:0];
               if (tBe[p][1]) w[15:8] = tWdata[p][15:8];
               shadow[int'(tAddr[p])] = w;
            end
            lastB = (p == 1);
         end
         aReq = 1'b0; bReq = 1'b0;
         idle(1);
      end

      $display("Result: errors=%0d of %0d checks", errCount, chkCount);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's external 16-bit asynchronous SRAM (18-bit word address, active-low CS/WE/OE/UB/LB). It lets the RISC-V SoC bus (port A) and the STM32 QSPI bridge (port B) share the single SRAM. Each access runs as a fixed setup/strobe/hold cycle. The block sits between the two requesters and the SB_IO tristate data pins at top level, on the `CLK`-domain main clock.

## Interface
- `WAIT_CYCLES`, default 2: strobe length in clocks for WE_n/OE_n; legal range 1..15.
- `CLK` in 1: clock.
- `reset_in` in 1: asynchronous, active-high reset.
- `a_req`, `b_req` in 1: request; held until the matching ack.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` in 18: word address.
- `a_wdata`, `b_wdata` in 16: write data.
- `a_be`, `b_be` in 2: byte enables; bit0 = low byte, bit1 = high byte.
- `a_ack`, `b_ack` out 1: one-cycle completion pulse.
- `a_rdata`, `b_rdata` out 16: read data; valid with ack and held until that port's next read ack.
- `sram_addr` out 18: SRAM address.
- `sram_dat_write` out 16: data driven to the pins.
- `sram_dat_oe` out 1: tristate output enable for the data pins.
- `sram_dat_read` in 16: data from the pins.
- `sram_cs_n`, `sram_we_n`, `sram_oe_n`, `sram_lb_n`, `sram_ub_n` out 1: SRAM strobes, active low.

## Operation
- FSM states: IDLE -> SETUP -> ACCESS (WAIT_CYCLES clocks) -> HOLD -> IDLE.
- **IDLE**: all strobes high, `sram_dat_oe` = 0. If any request is pending, grant one port, latch its `we`/`addr`/`wdata`/`be` into internal registers, then go to SETUP.
- **SETUP**: drive `sram_addr` and `cs_n` = 0.
  - lb_n/ub_n = ~be for writes; both 0 for reads.
  - Writes: `sram_dat_oe` = 1 and `sram_dat_write` = latched wdata.
- **ACCESS**: writes drive `we_n` = 0; reads drive `oe_n` = 0. A down-counter loaded with WAIT_CYCLES-1 decides when to leave. On the last ACCESS clock edge, `sram_dat_read` is registered into the granted port's rdata.
- **HOLD**: `we_n`/`oe_n` = 1. Address, CS, byte lanes and write data stay stable. The granted port's ack = 1. Next state is IDLE, so there is no back-to-back grant from HOLD.
- **Arbitration**: round-robin. On simultaneous requests, grant the port not served last. After reset, A wins the first tie.
- Requests and data are latched at grant. Deasserting req mid-transaction is ignored: the cycle completes and ack still pulses.
- If req is still high in the IDLE cycle after ack, it is a new transaction.
- A write with be = 00 runs the full cycle with both lanes disabled; no data is written.

## Timing
- Request first seen high in IDLE at cycle 0: SETUP at cycle 1, ACCESS at cycles 2..WAIT_CYCLES+1, HOLD/ack at cycle WAIT_CYCLES+2.
- Request-to-ack latency is WAIT_CYCLES+2 clocks. Throughput is one access per WAIT_CYCLES+3 clocks.
- Reset values, applied asynchronously and immediately, including mid-transaction:
  - `sram_cs_n`, `sram_we_n`, `sram_oe_n`, `sram_lb_n`, `sram_ub_n` = 1.
  - `sram_dat_oe` = 0; `sram_addr`, `sram_dat_write`, `a_rdata`, `b_rdata` = 0; acks = 0.
  - FSM = IDLE; round-robin pointer = "B last".
- An aborted transaction never acks.
- All outputs are registered; there is no combinational path from `*_req` to SRAM pins or acks.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority, A always wins over B. B can starve under continuous A traffic; this is the accepted trade-off.
- Not defined: round-robin as above.

## Structure
- Package `sram_arb_pkg` holds:
  - `SRAM_ADDR_W` = 18 and `SRAM_DATA_W` = 16.
  - the FSM state enum (IDLE, SETUP, ACCESS, HOLD).
  - the port-select typedef (PORT_A, PORT_B).
- Sub-module `rr_arbiter2`: 2-way arbiter with a last-grant pointer.
  - Inputs: requests and an update strobe.
  - Outputs: one-hot grant.
  - The `SRAM_ARB_FIXED_PRIO_EN` selection lives there.

## Test plan
- **Single write then read, WAIT_CYCLES=2**: A writes 0x1234 to 0x00010 with be=11.
  - Ack at cycle 4.
  - `we_n` low exactly during cycles 2-3, `sram_dat_oe` high during cycles 1-4.
  - A read of 0x00010 with the SRAM model returns 0x1234 on `a_rdata` with ack.
- **Byte lanes**: B writes 0xAB55 with be=01.
  - `lb_n`=0 and `ub_n`=1 during SETUP..HOLD.
  - The model's word goes from 0xFFFF to 0xFF55.
- **Simultaneous requests**: A and B both request from reset and hold req.
  - Grants alternate A, B, A, B.
  - Acks spaced 5 clocks apart.
  - With `SRAM_ARB_FIXED_PRIO_EN`, A is served continuously and `b_ack` never asserts.
- **Req dropped mid-cycle**: A deasserts req during ACCESS.
  - `a_ack` still pulses at cycle 4.
  - The FSM returns to IDLE with no extra access.
- **Reset mid-ACCESS**: assert `reset_in` during a write strobe.
  - `we_n`/`cs_n` go high and `sram_dat_oe` goes low within the same cycle, without waiting for a clock edge.
  - No ack follows; the next request after release completes normally.
- **WAIT_CYCLES=1 and 15**: ack latency is 3 and 17 clocks respectively.
